// File: rtl/serial_pattern_gen_pkg.sv
// Shared definitions for the serial pattern generator and its companion
// sequence detectors.
package serial_pattern_gen_pkg;

  typedef enum logic [1:0] {
    GEN_IDLE,
    GEN_SHIFT,
    GEN_GAP,
    GEN_DONE
  } gen_state_e;

  // Detector progress states: DET_Sn means n consecutive matching bits seen.
  typedef enum logic [2:0] {
    DET_S0,
    DET_S1,
    DET_S2,
    DET_S3,
    DET_S4
  } det_state_e;

  localparam int unsigned DET_RUN_LEN = 4;

endpackage

// File: rtl/serial_pattern_gen_piso_shift.sv
// Loadable parallel-in/serial-out shift register. The active field is
// left-aligned on load so the bit at start_idx is always presented first.
module piso_shift #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic             reload,
  input  logic [WIDTH-1:0] pattern_i,
  input  logic [LEN_W-1:0] start_idx,
  output logic             ser_o
);

  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] aligned;

  // ser_o is the bit leaving this cycle; the register already holds the one after it.
  always_comb begin
    aligned = pattern_i << (WIDTH - 1 - 32'(start_idx));
    pat_d   = pat_q;
    sh_d    = sh_q;
    ser_o   = sh_q[WIDTH-1];
    if (load) begin
      pat_d = aligned;
      sh_d  = aligned << 1;
      ser_o = aligned[WIDTH-1];
    end else if (reload) begin
      sh_d  = pat_q << 1;
      ser_o = pat_q[WIDTH-1];
    end else if (shift_en) begin
      sh_d  = sh_q << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q <= '0;
      sh_q  <= '0;
    end else begin
      pat_q <= pat_d;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial bit-stream transmitter: sends pattern[len-1:0] MSB first, reps times,
// with GAP idle-low cycles between repeats.
module serial_pattern_gen
  import serial_pattern_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] reps,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(WIDTH);

  gen_state_e       state_q, state_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0] len_m1_q, len_m1_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

  logic             load, shift_en, reload, ser_bit;
  logic [LEN_W-1:0] len_eff_m1;
  logic [CNT_W-1:0] reps_eff_m1;

  always_comb begin
    len_eff_m1  = ((len == '0) || (len > MAX_LEN)) ? MAX_LEN - LEN_W'(1)
                                                   : len - LEN_W'(1);
    reps_eff_m1 = (reps == '0) ? '0 : reps - CNT_W'(1);
  end

  piso_shift #(
    .WIDTH(WIDTH),
    .LEN_W(LEN_W)
  ) u_piso (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift_en (shift_en),
    .reload   (reload),
    .pattern_i(pattern),
    .start_idx(len_eff_m1),
    .ser_o    (ser_bit)
  );

  // bit_cnt_q is the index of the bit currently on out; rep_cnt_q counts repeats still to follow.
  always_comb begin
    state_d   = state_q;
    out_d     = 1'b0;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bit_cnt_d = bit_cnt_q;
    len_m1_d  = len_m1_q;
    rep_cnt_d = rep_cnt_q;
    gap_cnt_d = gap_cnt_q;
    load      = 1'b0;
    shift_en  = 1'b0;
    reload    = 1'b0;

    unique case (state_q)
      GEN_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_d   = GEN_SHIFT;
          out_d     = ser_bit;
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          bit_cnt_d = len_eff_m1;
          len_m1_d  = len_eff_m1;
          rep_cnt_d = reps_eff_m1;
        end
      end
      GEN_SHIFT: begin
        if (bit_cnt_q != '0) begin
          shift_en  = 1'b1;
          out_d     = ser_bit;
          valid_d   = 1'b1;
          bit_cnt_d = bit_cnt_q - LEN_W'(1);
        end else if (rep_cnt_q != '0) begin
          rep_cnt_d = rep_cnt_q - CNT_W'(1);
          if (GAP > 0) begin
            state_d   = GEN_GAP;
            gap_cnt_d = GAP_LAST;
          end else begin
            reload    = 1'b1;
            out_d     = ser_bit;
            valid_d   = 1'b1;
            bit_cnt_d = len_m1_q;
          end
        end else begin
          state_d = GEN_DONE;
          done_d  = 1'b1;
        end
      end
      GEN_GAP: begin
        if (gap_cnt_q == '0) begin
          reload    = 1'b1;
          state_d   = GEN_SHIFT;
          out_d     = ser_bit;
          valid_d   = 1'b1;
          bit_cnt_d = len_m1_q;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      GEN_DONE: begin
        state_d = GEN_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = GEN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= GEN_IDLE;
      out_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bit_cnt_q <= '0;
      len_m1_q  <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bit_cnt_q <= bit_cnt_d;
      len_m1_q  <= len_m1_d;
      rep_cnt_q <= rep_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: one instance with a single gap cycle, one
// back-to-back, checked cycle by cycle against a bit-list model.
module tb_serial_pattern_gen;

  localparam int W  = 8;
  localparam int LW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_a, start_b;
  logic [W-1:0]  pattern;
  logic [LW-1:0] len;
  logic [CW-1:0] reps;
  logic          out_a, valid_a, busy_a, done_a;
  logic          out_b, valid_b, busy_b, done_b;

  always #5 clk = ~clk;

  serial_pattern_gen #(.WIDTH(W), .LEN_W(LW), .CNT_W(CW), .GAP(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .pattern(pattern), .len(len),
    .reps(reps), .out(out_a), .valid(valid_a), .busy(busy_a), .done(done_a)
  );

  serial_pattern_gen #(.WIDTH(W), .LEN_W(LW), .CNT_W(CW), .GAP(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .pattern(pattern), .len(len),
    .reps(reps), .out(out_b), .valid(valid_b), .busy(busy_b), .done(done_b)
  );

  typedef struct packed {
    logic o;
    logic v;
    logic b;
    logic d;
  } obs_t;

  typedef struct {
    int          sel;
    logic [7:0]  pat;
    int          ln;
    int          rp;
    int          restart;
    logic [63:0] exp_bits;
    int          exp_n;
    int          exp_busy;
  } vec_t;

  int checks = 0;
  int errors = 0;

  function automatic obs_t sample(input int sel);
    obs_t s;
    if (sel != 0) s = {out_b, valid_b, busy_b, done_b};
    else          s = {out_a, valid_a, busy_a, done_a};
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Expected stream: the active bits MSB first per repeat, idle-low gaps, one done cycle, then idle.
  task automatic run_xfer(input int sel, input logic [7:0] pat, input int ln, input int rp,
                          input int restart_at, input string tag,
                          output logic [63:0] bits, output int nbits, output int nbusy);
    obs_t exp_q[$];
    obs_t got;
    int   l, r, g;
    l = (ln == 0 || ln > W) ? W : ln;
    r = (rp == 0) ? 1 : rp;
    g = (sel != 0) ? 0 : 1;
    for (int k = 0; k < r; k++) begin
      for (int i = l - 1; i >= 0; i--) exp_q.push_back({pat[i], 1'b1, 1'b1, 1'b0});
      if (k < r - 1)
        for (int j = 0; j < g; j++) exp_q.push_back(obs_t'(4'b0010));
    end
    exp_q.push_back(obs_t'(4'b0011));
    exp_q.push_back(obs_t'(4'b0000));
    exp_q.push_back(obs_t'(4'b0000));

    pattern = pat;
    len     = LW'(ln);
    reps    = CW'(rp);
    if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    bits  = '0;
    nbits = 0;
    nbusy = 0;
    for (int idx = 0; idx < exp_q.size(); idx++) begin
      got = sample(sel);
      check($sformatf("%s_c%0d", tag, idx), 64'(got), 64'(exp_q[idx]));
      if (got.v) begin
        bits = {bits[62:0], got.o};
        nbits++;
      end
      if (got.b) nbusy++;
      pattern = W'($urandom);
      len     = LW'($urandom);
      reps    = CW'($urandom);
      if (idx == restart_at) begin
        if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      @(negedge clk);
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  initial begin
    vec_t        tbl[9];
    logic [63:0] bits;
    int          nbits, nbusy;

    tbl[0] = '{0, 8'h0F, 8,  1, -1, 64'h0F,   8,  9};
    tbl[1] = '{0, 8'h0F, 4,  3, -1, 64'hFFF,  12, 15};
    tbl[2] = '{0, 8'hA5, 0,  1, -1, 64'hA5,   8,  9};
    tbl[3] = '{0, 8'hA5, 8,  0, -1, 64'hA5,   8,  9};
    tbl[4] = '{0, 8'hFE, 1,  1, -1, 64'h0,    1,  2};
    tbl[5] = '{0, 8'h01, 1,  2, -1, 64'h3,    2,  4};
    tbl[6] = '{0, 8'hB4, 8,  2,  3, 64'hB4B4, 16, 18};
    tbl[7] = '{0, 8'h3C, 12, 1, -1, 64'h3C,   8,  9};
    tbl[8] = '{1, 8'h05, 3,  2, -1, 64'h2D,   6,  7};

    reset   = 1'b1;
    start_a = 1'b1;
    start_b = 1'b1;
    pattern = 8'hFF;
    len     = '0;
    reps    = '0;
    repeat (3) @(negedge clk);
    check("reset_a", 64'(sample(0)), 64'h0);
    check("reset_b", 64'(sample(1)), 64'h0);
    start_a = 1'b0;
    start_b = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    check("idle_a", 64'(sample(0)), 64'h0);

    for (int t = 0; t < 9; t++) begin
      run_xfer(tbl[t].sel, tbl[t].pat, tbl[t].ln, tbl[t].rp, tbl[t].restart,
               $sformatf("vec%0d", t), bits, nbits, nbusy);
      check($sformatf("vec%0d_bits", t), bits, tbl[t].exp_bits);
      check($sformatf("vec%0d_nbits", t), 64'(nbits), 64'(tbl[t].exp_n));
      check($sformatf("vec%0d_busy", t), 64'(nbusy), 64'(tbl[t].exp_busy));
    end

    // Reset while bit 3 of 8'hC3 is on the line.
    pattern = 8'hC3;
    len     = LW'(8);
    reps    = CW'(1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_bit3", 64'(sample(0)), 64'(4'b0110));
    reset = 1'b1;
    @(negedge clk);
    check("rst_next", 64'(sample(0)), 64'h0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_quiet%0d", i), 64'(sample(0)), 64'h0);
    end
    run_xfer(0, 8'hC3, 8, 1, -1, "after_rst", bits, nbits, nbusy);
    check("after_rst_bits", bits, 64'hC3);
    check("after_rst_busy", 64'(nbusy), 64'd9);

    for (int t = 0; t < 24; t++) begin
      int         sel, ln, rp, rs;
      logic [7:0] pat;
      sel = int'($urandom_range(0, 1));
      pat = 8'($urandom);
      ln  = int'($urandom_range(0, 15));
      rp  = int'($urandom_range(0, 3));
      rs  = ($urandom_range(0, 3) == 0) ? 1 : -1;
      run_xfer(sel, pat, ln, rp, rs, $sformatf("rnd%0d", t), bits, nbits, nbusy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_pattern_gen.md
Name: serial_pattern_gen

Overview:
Serial bit-stream transmitter: the stimulus-side counterpart of the team's serial sequence detectors. It loads a parallel pattern and shifts it out one bit per clock, MSB of the active field first. It can repeat the pattern N times with zero-filled gaps between repeats. It drives a detector's `in` directly, either in benches or on-board from switches.

Parameters:
WIDTH, 8, maximum pattern length in bits
LEN_W, 4, width of len input; must hold the value WIDTH
CNT_W, 4, width of reps input / repeat counter
GAP, 1, zero cycles inserted between repeats (0 = back-to-back)

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  synchronous, active-high reset
start  input  1  request transmission; sampled only in IDLE
pattern  input  WIDTH  bits to send; active field is pattern[len-1:0]
len  input  LEN_W  bits per repeat, 1..WIDTH; 0 or >WIDTH treated as WIDTH
reps  input  CNT_W  number of transmissions; 0 treated as 1
out  output  1  serial data bit (registered)
valid  output  1  out carries a pattern bit this cycle
busy  output  1  high from the cycle after start through DONE
done  output  1  one-cycle pulse after the last bit of the last repeat

Behaviour:
- Reset: state=IDLE; out=0, valid=0, busy=0, done=0; shift register, bit counter and repeat counter cleared. Reset overrides start and any in-progress transfer. Transfer is abandoned without a done pulse.
- All outputs are registered and change only on posedge clk.
- FSM states: IDLE, SHIFT, GAP, DONE.
- IDLE: start=1 at edge k latches pattern, effective len (L) and effective reps (R), and moves to SHIFT. Bit pattern[L-1] appears on out with valid=1 in the cycle after edge k. Latency is 1 cycle.
- SHIFT: each cycle presents the next lower bit. After bit 0 of the active field:
  - if repeats remain and GAP>0, go to GAP;
  - if repeats remain and GAP=0, the next cycle starts bit L-1 of the next repeat;
  - otherwise go to DONE.
- GAP: out=0, valid=0 for exactly GAP cycles. Then go to SHIFT, restarting at bit L-1 from the latched copy.
- DONE: one cycle with done=1, busy=1, out=0, valid=0. Then go to IDLE.
- In IDLE and DONE, out=0 and valid=0. The line idles low so a downstream run-of-ones detector sees no false run.
- start while busy is ignored (no queueing). start in the DONE cycle is also ignored.
- pattern, len and reps may change after the start edge without effect: latched copies are used throughout.
- Total busy cycles = R*L + (R-1)*GAP + 1 (the +1 is DONE).
- Counters: the bit counter counts down from L-1 to 0. The repeat counter counts down from R-1 to 0. Neither counter wraps; terminal values drive the FSM transitions.
- Bits above L-1 in pattern are never transmitted.

Decomposition:
- Shared package holds the FSM state encoding (IDLE, SHIFT, GAP, DONE) as localparams. The same package holds the detector state constants so generator and detector benches share one definition.
- One natural sub-module: `piso_shift`, a loadable WIDTH-bit parallel-in/serial-out shift register with load, shift_en and start-bit index.
- The FSM and both counters stay in the top module.

Test Plan:
- Single repeat: pattern=8'b0000_1111, len=8, reps=1, start one cycle. Required:
  - valid high 8 cycles with out=0,0,0,0,1,1,1,1;
  - done pulses the next cycle;
  - busy high 9 cycles;
  - IDLE one cycle after done.
- Repeats with gap: GAP=1, pattern=4'b1111, len=4, reps=3. Required:
  - out = 1111 0 1111 0 1111, valid low only during the two gap cycles;
  - done after 14 data/gap cycles;
  - when fed to the four-ones detector, its out rises once per repeat.
- Edge encodings: len=0 with pattern=8'hA5 sends all 8 bits 1,0,1,0,0,1,0,1. reps=0 behaves as one repeat. len=1 sends only pattern[0].
- Start while busy: pulse start again mid-SHIFT with a different pattern. Required: the stream is unchanged, exactly one done pulse, no second transfer.
- Reset mid-operation: assert reset during SHIFT bit 3. Required:
  - next edge: out=0, valid=0, busy=0;
  - no done pulse;
  - a fresh start afterwards transmits correctly from bit L-1.
- Back-to-back with GAP=0: pattern=3'b101, len=3, reps=2. Required: out=1,0,1,1,0,1 contiguous with valid high 6 cycles, then done.
